// File: rtl/tgt_pkg.sv
// Shared types, sizes and the compact-difficulty (nBits) expansion function
// used by the target streamer and the host-side target readback.
package tgt_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, ARMED, SEND} tgt_state_t;

  localparam int TGT_W     = 256;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;

  // A 288-bit intermediate keeps the bits that spill past 256 visible, so overflow can be detected.
  // A negative or overflowing value expands to zero and raises ovf_or_neg. A zero mantissa is never an error.
  function automatic logic [TGT_W-1:0] nbits_expand(input logic [31:0] nb, output logic ovf_or_neg);
    logic [7:0]   e;
    logic [23:0]  m;
    logic [10:0]  sh;
    logic [287:0] wide;
    e    = nb[31:24];
    m    = nb[23:0];
    wide = {264'd0, m};
    if (e <= 8'd3) begin
      sh   = {(8'd3 - e), 3'b000};
      wide = wide >> sh;
    end else begin
      sh   = {(e - 8'd3), 3'b000};
      wide = wide << sh;
    end
    ovf_or_neg = (m != 24'd0) && (m[23] || (e > 8'd34) || (|wide[287:256]));
    return ovf_or_neg ? '0 : wide[TGT_W-1:0];
  endfunction

endpackage

// File: rtl/target_streamer_if.sv
// Host/comparator-facing signal bundle of the target streamer.
// The master modport is the driving (host/job) side; the slave modport is the streamer.
interface target_streamer_if;
  logic [31:0] nbits;
  logic        nbits_valid;
  logic        nbits_ready;
  logic        start;
  logic        stop;
  logic        stop_ack_comp;
  logic [31:0] target;
  logic        target_we;
  logic        tgt_loaded;
  logic        busy;
  logic        err;
  logic        clamped;

  modport master (
    output nbits, nbits_valid, start, stop, stop_ack_comp,
    input  nbits_ready, target, target_we, tgt_loaded, busy, err, clamped
  );

  modport slave (
    input  nbits, nbits_valid, start, stop, stop_ack_comp,
    output nbits_ready, target, target_we, tgt_loaded, busy, err, clamped
  );
endinterface

// File: rtl/nbits_expander.sv
// Combinational wrapper around nbits_expand: compact nBits word to a 256-bit target.
module nbits_expander
  import tgt_pkg::*;
(
  input  logic [31:0]      nbits,
  output logic [TGT_W-1:0] tgt,
  output logic             ovf_or_neg
);

  always_comb begin
    ovf_or_neg = 1'b0;
    tgt        = nbits_expand(nbits, ovf_or_neg);
  end

endmodule

// File: rtl/target_streamer.sv
// Expands nBits into a 256-bit target and streams it as 8 x 32-bit words, LS word first, on each start.
// Optional clamp to the PoW limit: define TGT_POWLIMIT_CLAMP_EN.
module target_streamer #(
  parameter int          WORD_W          = 32,
  parameter int          NUM_WORDS       = 8,
  parameter logic [31:0] POW_LIMIT_NBITS = 32'h1d00ffff
) (
  input  logic              clk,
  input  logic              rst,
  target_streamer_if.slave  bus
);
  import tgt_pkg::*;

  tgt_state_t           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [TGT_W-1:0]     tgt_q, tgt_d;
  logic [31:0]          nbits_q, nbits_d;
  logic                 err_q, err_d;
  logic [TGT_W-1:0]     raw_tgt;
  logic                 raw_bad;
  logic                 go;
  logic                 accept;
  logic [WORD_W-1:0]    words [NUM_WORDS];

  nbits_expander u_expand (.nbits(nbits_q), .tgt(raw_tgt), .ovf_or_neg(raw_bad));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      assign words[gi] = tgt_q[gi*WORD_W +: WORD_W];
    end
  endgenerate

`ifdef TGT_POWLIMIT_CLAMP_EN
  logic [TGT_W-1:0] limit_tgt;
  logic             limit_bad;
  logic             clamped_q, clamped_d;

  nbits_expander u_limit (.nbits(POW_LIMIT_NBITS), .tgt(limit_tgt), .ovf_or_neg(limit_bad));
  assign bus.clamped = clamped_q;
`else
  assign bus.clamped = 1'b0;
`endif

  // start takes priority over a simultaneous nbits offer while armed.
  assign go              = bus.start && bus.stop_ack_comp && !bus.stop;
  assign bus.nbits_ready = (state_q == IDLE) || ((state_q == ARMED) && !go);
  assign accept          = bus.nbits_valid && bus.nbits_ready;

  assign bus.busy       = (state_q == SEND);
  assign bus.tgt_loaded = (state_q == ARMED) || (state_q == SEND);
  assign bus.target_we  = (state_q == SEND) && !bus.stop;
  assign bus.target     = (state_q == SEND) ? words[cnt_q] : '0;
  assign bus.err        = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    nbits_d = nbits_q;
    err_d   = err_q;
`ifdef TGT_POWLIMIT_CLAMP_EN
    clamped_d = clamped_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          nbits_d = bus.nbits;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        tgt_d   = raw_tgt;
        err_d   = raw_bad;
        state_d = ARMED;
`ifdef TGT_POWLIMIT_CLAMP_EN
        clamped_d = 1'b0;
        if (!raw_bad && !limit_bad && (raw_tgt > limit_tgt)) begin
          tgt_d     = limit_tgt;
          clamped_d = 1'b1;
        end
`endif
      end
      ARMED: begin
        if (go) begin
          cnt_d   = '0;
          state_d = SEND;
        end else if (accept) begin
          nbits_d = bus.nbits;
          state_d = EXPAND;
        end
      end
      SEND: begin
        // A stopped stream is abandoned; the next start begins again at word 0.
        if (bus.stop || (cnt_q == 3'(NUM_WORDS - 1))) begin
          cnt_d   = '0;
          state_d = ARMED;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      nbits_q <= '0;
      err_q   <= 1'b0;
`ifdef TGT_POWLIMIT_CLAMP_EN
      clamped_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      nbits_q <= nbits_d;
      err_q   <= err_d;
`ifdef TGT_POWLIMIT_CLAMP_EN
      clamped_q <= clamped_d;
`endif
    end
  end

endmodule
